// File: rtl/fpu_add_scheduler.sv
// -----------------------------------------------------------------------------
// fpu_add_scheduler
//
// Shares one pipelined FP32 add unit among N_REQ requesters. A round-robin
// arbiter grants one requester per cycle among those that are valid and have
// no operation in flight. The granted operands are forwarded to the pipeline
// with the requester index as a tag. Each result coming back out of the
// pipeline is routed to its owner as a one-cycle response pulse. That response
// also frees the owner so it can issue again.
//
// Ports
//   clk_i          clock, rising edge
//   rst_ni         asynchronous reset, active low
//   req_valid_i    [N_REQ]      requester r has an op pending
//   req_a_i        [N_REQ][32]  operand A per requester
//   req_b_i        [N_REQ][32]  operand B per requester
//   req_ready_o    [N_REQ]      one-hot grant, handshake = valid & ready
//   issue_valid_o               op presented to the add pipeline this cycle
//   issue_a_o      [32]         operand A to the pipeline
//   issue_b_o      [32]         operand B to the pipeline
//   issue_tag_o    [TAG_W]      owner index of the issued op
//   res_valid_i                 pipeline result valid
//   res_data_i     [32]         pipeline result
//   res_tag_i      [TAG_W]      tag returned with the result
//   rsp_valid_o    [N_REQ]      one-hot response pulse to the owner
//   rsp_data_o     [32]         response data, shared by all requesters
//   busy_o         [N_REQ]      requester r has an op in flight
//   err_o                       sticky protocol error
// -----------------------------------------------------------------------------
module fpu_add_scheduler #(
  parameter int N_REQ = 2,
  parameter int TAG_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [N_REQ-1:0]       req_valid_i,
  input  logic [N_REQ-1:0][31:0] req_a_i,
  input  logic [N_REQ-1:0][31:0] req_b_i,
  output logic [N_REQ-1:0]       req_ready_o,
  output logic                   issue_valid_o,
  output logic [31:0]            issue_a_o,
  output logic [31:0]            issue_b_o,
  output logic [TAG_W-1:0]       issue_tag_o,
  input  logic                   res_valid_i,
  input  logic [31:0]            res_data_i,
  input  logic [TAG_W-1:0]       res_tag_i,
  output logic [N_REQ-1:0]       rsp_valid_o,
  output logic [31:0]            rsp_data_o,
  output logic [N_REQ-1:0]       busy_o,
  output logic                   err_o
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [N_REQ-1:0] busy_q;
  logic [TAG_W-1:0] rr_ptr_q;
  logic             err_q;
  logic             issue_valid_q;
  logic [31:0]      issue_a_q;
  logic [31:0]      issue_b_q;
  logic [TAG_W-1:0] issue_tag_q;
  logic [N_REQ-1:0] rsp_valid_q;
  logic [31:0]      rsp_data_q;

  // ---------------------------------------------------------------------------
  // Round-robin arbitration
  // The search runs in two passes. The first pass looks only at indices at or
  // above rr_ptr. The second pass looks at all indices and supplies the
  // wrapped-around winner. A hit in the first pass always takes priority over
  // the second. Only busy_q feeds eligibility, so a result returning in the
  // same cycle cannot make its owner grantable until the next cycle.
  // ---------------------------------------------------------------------------
  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] grant;
  logic [TAG_W-1:0] grant_idx;
  logic             grant_vld;
  logic [TAG_W-1:0] hi_idx;
  logic             hi_vld;
  logic [TAG_W-1:0] lo_idx;
  logic             lo_vld;

  // NOTE: every signal written in an always_comb gets a default at the top of
  // the block. Without that, any path that skips an assignment infers a latch.
  always_comb begin
    elig      = req_valid_i & ~busy_q;
    hi_idx    = '0;
    hi_vld    = 1'b0;
    lo_idx    = '0;
    lo_vld    = 1'b0;
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;

    for (int i = 0; i < N_REQ; i++) begin
      if (!hi_vld && elig[i] && (i >= int'(rr_ptr_q))) begin
        hi_vld = 1'b1;
        hi_idx = TAG_W'(i);
      end
    end

    for (int i = 0; i < N_REQ; i++) begin
      if (!lo_vld && elig[i]) begin
        lo_vld = 1'b1;
        lo_idx = TAG_W'(i);
      end
    end

    if (hi_vld) begin
      grant_vld = 1'b1;
      grant_idx = hi_idx;
    end else if (lo_vld) begin
      grant_vld = 1'b1;
      grant_idx = lo_idx;
    end

    for (int i = 0; i < N_REQ; i++) begin
      grant[i] = grant_vld && (grant_idx == TAG_W'(i));
    end
  end

  // The grant is combinational from req_valid_i. It is masked while reset is
  // asserted so that every output reads zero during reset.
  assign req_ready_o = grant & {N_REQ{rst_ni}};

  // ---------------------------------------------------------------------------
  // Result decode and protocol checking
  // res_hit is the one-hot owner of the returning result. It is all zero when
  // the tag is outside 0..N_REQ-1. That same vector drives the response
  // pulse, the busy clear and the "result for an idle owner" error check.
  // ---------------------------------------------------------------------------
  logic [N_REQ-1:0] res_hit;
  logic             res_err;

  always_comb begin
    res_hit = '0;
    for (int i = 0; i < N_REQ; i++) begin
      res_hit[i] = res_valid_i && (res_tag_i == TAG_W'(i));
    end
    res_err = res_valid_i && ((res_hit & busy_q) == '0);
  end

  // ---------------------------------------------------------------------------
  // Next-state values
  // A grant and a return for the same requester can only coincide on a
  // protocol error, because a granted requester was not busy. In that case
  // the new grant wins, since its op really is in flight.
  // ---------------------------------------------------------------------------
  logic [N_REQ-1:0] busy_d;
  logic [TAG_W-1:0] rr_ptr_d;

  always_comb begin
    busy_d   = (busy_q & ~res_hit) | grant;
    rr_ptr_d = rr_ptr_q;
    if (grant_vld) begin
      rr_ptr_d = (grant_idx == TAG_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // NOTE: the operand and data registers are reset along with the control
  // state. They drive module outputs directly, and those outputs must read
  // zero during reset.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples the pre-edge values, whatever order the statements are in.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q        <= '0;
      rr_ptr_q      <= '0;
      err_q         <= 1'b0;
      issue_valid_q <= 1'b0;
      issue_a_q     <= '0;
      issue_b_q     <= '0;
      issue_tag_q   <= '0;
      rsp_valid_q   <= '0;
      rsp_data_q    <= '0;
    end else begin
      busy_q        <= busy_d;
      rr_ptr_q      <= rr_ptr_d;
      err_q         <= err_q | res_err;
      issue_valid_q <= grant_vld;
      if (grant_vld) begin
        issue_a_q   <= req_a_i[grant_idx];
        issue_b_q   <= req_b_i[grant_idx];
        issue_tag_q <= grant_idx;
      end
      // An out-of-range tag produces no pulse and leaves the data bus alone.
      rsp_valid_q   <= res_hit;
      if (|res_hit) begin
        rsp_data_q  <= res_data_i;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign issue_valid_o = issue_valid_q;
  assign issue_a_o     = issue_a_q;
  assign issue_b_o     = issue_b_q;
  assign issue_tag_o   = issue_tag_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_data_o    = rsp_data_q;
  assign busy_o        = busy_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_fpu_add_scheduler.sv
// -----------------------------------------------------------------------------
// tb_fpu_add_scheduler
//
// Drives two scheduler instances, one with N_REQ=2 (index 0) and one with
// N_REQ=4 (index 1). Each instance is compared every cycle against a
// behavioural model. The model is a list of per-requester busy flags plus a
// round-robin pointer. Grants come from a plain search over the requester
// list. A delay-line pipeline emulator can echo issued ops back as results,
// or results can be injected by hand for the directed scenarios.
// -----------------------------------------------------------------------------
module tb_fpu_add_scheduler;

  localparam int PIPE_L = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- N_REQ = 2 instance ----------------
  logic [1:0]       valid2;
  logic [1:0][31:0] a2, b2;
  logic [1:0]       ready2;
  logic             iv2;
  logic [31:0]      ia2, ib2;
  logic [0:0]       it2;
  logic             rv2;
  logic [31:0]      rd2;
  logic [0:0]       rt2;
  logic [1:0]       rspv2;
  logic [31:0]      rspd2;
  logic [1:0]       busy2;
  logic             err2;

  fpu_add_scheduler #(.N_REQ(2)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(valid2), .req_a_i(a2), .req_b_i(b2), .req_ready_o(ready2),
    .issue_valid_o(iv2), .issue_a_o(ia2), .issue_b_o(ib2), .issue_tag_o(it2),
    .res_valid_i(rv2), .res_data_i(rd2), .res_tag_i(rt2),
    .rsp_valid_o(rspv2), .rsp_data_o(rspd2), .busy_o(busy2), .err_o(err2)
  );

  // ---------------- N_REQ = 4 instance ----------------
  logic [3:0]       valid4;
  logic [3:0][31:0] a4, b4;
  logic [3:0]       ready4;
  logic             iv4;
  logic [31:0]      ia4, ib4;
  logic [1:0]       it4;
  logic             rv4;
  logic [31:0]      rd4;
  logic [1:0]       rt4;
  logic [3:0]       rspv4;
  logic [31:0]      rspd4;
  logic [3:0]       busy4;
  logic             err4;

  fpu_add_scheduler #(.N_REQ(4)) u_dut4 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(valid4), .req_a_i(a4), .req_b_i(b4), .req_ready_o(ready4),
    .issue_valid_o(iv4), .issue_a_o(ia4), .issue_b_o(ib4), .issue_tag_o(it4),
    .res_valid_i(rv4), .res_data_i(rd4), .res_tag_i(rt4),
    .rsp_valid_o(rspv4), .rsp_data_o(rspd4), .busy_o(busy4), .err_o(err4)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Stimulus per instance
  logic [7:0]  s_valid [2];
  logic [31:0] s_a     [2][8];
  logic [31:0] s_b     [2][8];
  logic        s_rv    [2];
  int          s_rt    [2];
  logic [31:0] s_rd    [2];
  bit          auto_mode [2];

  // Behavioural model per instance
  logic [7:0]  m_busy [2];
  int          m_ptr  [2];
  logic        m_err  [2];
  logic        m_iv   [2];
  logic [31:0] m_ia   [2];
  logic [31:0] m_ib   [2];
  int          m_itag [2];
  logic [7:0]  m_rspv [2];
  logic [31:0] m_rspd [2];

  // Pipeline emulator: a plain delay line of issued ops
  logic        p_v [2][PIPE_L];
  int          p_t [2][PIPE_L];
  logic [31:0] p_d [2][PIPE_L];

  logic [7:0]  last_ready [2];

  function automatic int nreq(input int d);
    return (d == 0) ? 2 : 4;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    valid2 = s_valid[0][1:0];
    valid4 = s_valid[1][3:0];
    for (int i = 0; i < 2; i++) begin
      a2[i] = s_a[0][i];
      b2[i] = s_b[0][i];
    end
    for (int i = 0; i < 4; i++) begin
      a4[i] = s_a[1][i];
      b4[i] = s_b[1][i];
    end
    rv2 = s_rv[0];
    rt2 = s_rt[0][0:0];
    rd2 = s_rd[0];
    rv4 = s_rv[1];
    rt4 = s_rt[1][1:0];
    rd4 = s_rd[1];
  endtask

  task automatic observe(input int d, output logic [7:0] rdy, output logic [7:0] bsy,
                         output logic [7:0] rspv, output logic iv, output logic er,
                         output logic [31:0] ia, output logic [31:0] ib,
                         output logic [31:0] rspd, output int itag);
    if (d == 0) begin
      rdy = 8'(ready2); bsy = 8'(busy2); rspv = 8'(rspv2); iv = iv2; er = err2;
      ia = ia2; ib = ib2; rspd = rspd2; itag = int'(it2);
    end else begin
      rdy = 8'(ready4); bsy = 8'(busy4); rspv = 8'(rspv4); iv = iv4; er = err4;
      ia = ia4; ib = ib4; rspd = rspd4; itag = int'(it4);
    end
  endtask

  // First requester that is valid and idle, scanning from the pointer with wrap.
  function automatic int model_grant(input int d);
    for (int k = 0; k < nreq(d); k++) begin
      int idx;
      idx = (m_ptr[d] + k) % nreq(d);
      if (s_valid[d][idx] && !m_busy[d][idx]) return idx;
    end
    return -1;
  endfunction

  // One clock cycle: inputs applied after the falling edge, grant checked
  // before the rising edge, registered outputs checked 1 time unit after it.
  task automatic step();
    int          g [2];
    logic [7:0]  rdy, bsy, rspv, set_m, clr_m;
    logic        iv, er;
    logic [31:0] ia, ib, rspd;
    int          itag;
    drive();
    #2;
    for (int d = 0; d < 2; d++) begin
      g[d] = rst_n ? model_grant(d) : -1;
      observe(d, rdy, bsy, rspv, iv, er, ia, ib, rspd, itag);
      last_ready[d] = rdy;
      check($sformatf("d%0d_ready", d), 32'(rdy), (g[d] >= 0) ? (32'd1 << g[d]) : 32'd0);
      if (!rst_n) begin
        m_busy[d] = '0; m_ptr[d] = 0; m_err[d] = 1'b0; m_iv[d] = 1'b0;
        m_ia[d] = '0; m_ib[d] = '0; m_itag[d] = 0; m_rspv[d] = '0; m_rspd[d] = '0;
      end else begin
        set_m = '0;
        clr_m = '0;
        m_iv[d] = 1'b0;
        if (g[d] >= 0) begin
          m_iv[d]   = 1'b1;
          m_ia[d]   = s_a[d][g[d]];
          m_ib[d]   = s_b[d][g[d]];
          m_itag[d] = g[d];
          set_m[g[d]] = 1'b1;
          m_ptr[d]  = (g[d] + 1) % nreq(d);
        end
        m_rspv[d] = '0;
        if (s_rv[d]) begin
          if (s_rt[d] < nreq(d)) begin
            m_rspv[d][s_rt[d]] = 1'b1;
            m_rspd[d] = s_rd[d];
            if (!m_busy[d][s_rt[d]]) m_err[d] = 1'b1;
            clr_m[s_rt[d]] = 1'b1;
          end else begin
            m_err[d] = 1'b1;
          end
        end
        m_busy[d] = (m_busy[d] & ~clr_m) | set_m;
      end
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      observe(d, rdy, bsy, rspv, iv, er, ia, ib, rspd, itag);
      check($sformatf("d%0d_issue_valid", d), 32'(iv), 32'(m_iv[d]));
      check($sformatf("d%0d_issue_tag", d), itag, m_itag[d]);
      check($sformatf("d%0d_issue_a", d), ia, m_ia[d]);
      check($sformatf("d%0d_issue_b", d), ib, m_ib[d]);
      check($sformatf("d%0d_rsp_valid", d), 32'(rspv), 32'(m_rspv[d]));
      check($sformatf("d%0d_rsp_data", d), rspd, m_rspd[d]);
      check($sformatf("d%0d_busy", d), 32'(bsy), 32'(m_busy[d]));
      check($sformatf("d%0d_err", d), 32'(er), 32'(m_err[d]));
      // Advance the pipeline emulator and pick the result for the next cycle.
      for (int s = PIPE_L - 1; s > 0; s--) begin
        p_v[d][s] = p_v[d][s-1];
        p_t[d][s] = p_t[d][s-1];
        p_d[d][s] = p_d[d][s-1];
      end
      p_v[d][0] = rst_n && m_iv[d];
      p_t[d][0] = m_itag[d];
      p_d[d][0] = m_ia[d] + m_ib[d];
      if (!rst_n) begin
        for (int s = 0; s < PIPE_L; s++) p_v[d][s] = 1'b0;
      end
      if (auto_mode[d]) begin
        s_rv[d] = p_v[d][PIPE_L-1];
        s_rt[d] = p_t[d][PIPE_L-1];
        s_rd[d] = p_d[d][PIPE_L-1];
      end else begin
        s_rv[d] = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic randomize_ops(input int d);
    for (int i = 0; i < 8; i++) begin
      s_a[d][i] = $urandom;
      s_b[d][i] = $urandom;
    end
  endtask

  // Hold reset for three cycles under random inputs, then release it with
  // every requester idle.
  task automatic do_reset();
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      for (int d = 0; d < 2; d++) begin
        s_valid[d] = 8'($urandom);
        s_rv[d]    = 1'($urandom);
        s_rt[d]    = $urandom_range(0, nreq(d) - 1);
        s_rd[d]    = $urandom;
        randomize_ops(d);
      end
      step();
    end
    for (int d = 0; d < 2; d++) begin
      s_valid[d]   = '0;
      s_rv[d]      = 1'b0;
      auto_mode[d] = 1'b0;
    end
    rst_n = 1'b1;
  endtask

  logic [7:0] rr_obs [6];
  logic [7:0] rr_exp [6];

  initial begin
    for (int d = 0; d < 2; d++) begin
      s_valid[d] = '0; s_rv[d] = 1'b0; s_rt[d] = 0; s_rd[d] = '0; auto_mode[d] = 1'b0;
      randomize_ops(d);
      for (int s = 0; s < PIPE_L; s++) begin
        p_v[d][s] = 1'b0; p_t[d][s] = 0; p_d[d][s] = '0;
      end
    end
    rr_exp = '{8'h01, 8'h02, 8'h00, 8'h00, 8'h01, 8'h02};
    @(negedge clk);

    // 1. Reset under random inputs, then the first grant goes to requester 0.
    do_reset();
    s_valid[0] = 8'h01;
    s_valid[1] = 8'h0F;
    auto_mode[0] = 1'b1;
    auto_mode[1] = 1'b1;
    step();
    check("t1_first_grant_n2", 32'(last_ready[0]), 32'h1);
    check("t1_first_grant_n4", 32'(last_ready[1]), 32'h1);
    for (int c = 0; c < 8; c++) step();

    // 2. Round robin, both requesters always valid, results echoed back.
    do_reset();
    s_valid[0]   = 8'h03;
    auto_mode[0] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      rr_obs[c] = last_ready[0];
    end
    for (int c = 0; c < 6; c++) begin
      check($sformatf("t2_rr_cycle%0d", c), 32'(rr_obs[c]), 32'(rr_exp[c]));
    end
    for (int c = 0; c < 10; c++) step();

    // 3. Single op from requester 1, result returned by hand.
    do_reset();
    s_valid[0]   = 8'h02;
    s_a[0][1]    = 32'h3F80_0000;
    s_b[0][1]    = 32'h4000_0000;
    step();
    check("t3_grant", 32'(last_ready[0]), 32'h2);
    check("t3_issue_valid", 32'(iv2), 32'h1);
    check("t3_issue_tag", 32'(it2), 32'h1);
    check("t3_issue_a", ia2, 32'h3F80_0000);
    check("t3_issue_b", ib2, 32'h4000_0000);
    s_valid[0] = 8'h00;
    step();
    step();
    s_rv[0] = 1'b1;
    s_rt[0] = 1;
    s_rd[0] = 32'h4040_0000;
    step();
    check("t3_rsp_valid", 32'(rspv2), 32'h2);
    check("t3_rsp_data", rspd2, 32'h4040_0000);
    check("t3_busy_clear", 32'(busy2), 32'h0);
    step();
    check("t3_rsp_pulse_end", 32'(rspv2), 32'h0);
    check("t3_rsp_data_hold", rspd2, 32'h4040_0000);

    // 4. A result for requester 0 while it is still requesting.
    s_valid[0] = 8'h01;
    step();
    check("t4_grant0", 32'(last_ready[0]), 32'h1);
    s_rv[0] = 1'b1;
    s_rt[0] = 0;
    s_rd[0] = 32'hCAFE_0001;
    step();
    check("t4_not_granted_same_cycle", 32'(last_ready[0]), 32'h0);
    check("t4_rsp_valid", 32'(rspv2), 32'h1);
    step();
    check("t4_granted_next_cycle", 32'(last_ready[0]), 32'h1);
    check("t4_no_err", 32'(err2), 32'h0);

    // 5. A result for an idle requester sets the sticky error flag.
    do_reset();
    s_rv[0] = 1'b1;
    s_rt[0] = 1;
    s_rd[0] = 32'h1234_5678;
    step();
    check("t5_err_set", 32'(err2), 32'h1);
    check("t5_rsp_still_pulsed", 32'(rspv2), 32'h2);
    for (int c = 0; c < 3; c++) step();
    check("t5_err_sticky", 32'(err2), 32'h1);

    // 6. Pointer wrap on the four-requester instance.
    do_reset();
    s_valid[1] = 8'h04;
    step();
    check("t6_grant2", 32'(last_ready[1]), 32'h4);
    s_valid[1] = 8'h09;
    step();
    check("t6_grant3", 32'(last_ready[1]), 32'h8);
    check("t6_tag3", 32'(it4), 32'h3);
    step();
    check("t6_grant0_wrap", 32'(last_ready[1]), 32'h1);
    check("t6_tag0", 32'(it4), 32'h0);

    // 7. Random traffic on both instances, with the pipeline emulator echoing results.
    do_reset();
    auto_mode[0] = 1'b1;
    auto_mode[1] = 1'b1;
    for (int c = 0; c < 400; c++) begin
      for (int d = 0; d < 2; d++) begin
        s_valid[d] = 8'($urandom);
        randomize_ops(d);
      end
      step();
    end
    check("t7_no_err_n2", 32'(err2), 32'h0);
    check("t7_no_err_n4", 32'(err4), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
